sp_ram_arbiter: RTL and testbench
=================================

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
- REQ-001 SHALL have parameter ADDR_W, default 3, RAM address width (depth 2**ADDR_W).
- REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
- REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
- REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
- REQ-005 SHALL have ports reqN_valid, input, 1, requester N (N=0,1) presents an access.
- REQ-006 SHALL have ports reqN_ready, output, 1, the arbiter accepts requester N's access this cycle.
- REQ-007 SHALL have ports reqN_we, input, 1, 1=write, 0=read.
- REQ-008 SHALL have ports reqN_addr, input, ADDR_W, access address.
- REQ-009 SHALL have ports reqN_wdata, input, DATA_W, write data.
- REQ-010 SHALL have ports rspN_valid, output, 1, one-cycle pulse carrying read data for requester N.
- REQ-011 SHALL have ports rspN_rdata, output, DATA_W, read data, meaningful only while rspN_valid=1.
- REQ-012 SHALL have port init_done, output, 1, 1 once the post-reset RAM clear has completed.

Function
- REQ-013 SHALL implement the FSM states INIT and RUN; reset enters INIT.
- REQ-014 SHALL, in INIT, write 0 to addresses 0..2**ADDR_W-1 in ascending order, one per cycle, using an internal counter, then enter RUN on the cycle after the last write.
- REQ-015 SHALL hold both reqN_ready=0 in INIT and keep init_done=0 until RUN is entered.
- REQ-016 SHALL, in RUN, assert reqN_ready combinationally only for the single granted requester, and only while its reqN_valid=1.
- REQ-017 SHALL grant the sole valid requester, and round-robin when both are valid: the winner is the requester not granted last.
- REQ-018 SHALL initialise last-grant to requester 1 so that requester 0 wins the first contention.
- REQ-019 SHALL update last-grant only on a completed handshake (valid && ready).
- REQ-020 SHALL perform a write into the RAM on the handshake edge.
- REQ-021 SHALL, for a read accepted at edge T, pulse rspN_valid=1 for the whole cycle following T for the granting requester only, with the other rsp valid held at 0.
- REQ-022 SHALL not back-pressure responses; one accepted access per cycle is sustainable.
- REQ-023 SHALL, for back-to-back accesses to the same address with a write at T and a read at T+1, return the newly written data.
- REQ-024 SHALL drive rspN_rdata from the RAM output, with no extra pipeline stage.
- REQ-025 SHALL leave the RAM idle (write enable 0) in a cycle with no handshake.

Reset
- REQ-026 SHALL, with rst_n=0 at a rising edge, enter INIT with counter=0, last-grant=1, init_done=0, both reqN_ready=0 and both rspN_valid=0.
- REQ-027 SHALL, on reset mid-operation (INIT or RUN), drop any pending response pulse and restart the full clear.
- REQ-028 SHALL not require RAM contents to be reset other than through the INIT clear.

Structure
- REQ-029 SHALL place the FSM state encoding (INIT, RUN) and the requester count (2) in the shared package sp_ram_pkg.
- REQ-030 SHALL instantiate exactly one sub-module, single_port_ram, as the storage (ports addr, data_in, we, clk, data_out), with a registered, 1-cycle read.
- REQ-031 SHALL use a 1-bit last-grant register and a 1-bit response-owner register.

Verification
- REQ-032 SHALL cover post-reset clear: release rst_n, then read addr 5 on req0 -> init_done rises after 8 clear cycles, and rsp0_rdata=8'h00.
- REQ-033 SHALL cover write then read on one requester: req0 writes 8'hA1@0 and 8'hB2@1, then reads 0 and 1 -> rsp0_rdata=A1, then B2, one cycle after each read handshake.
- REQ-034 SHALL cover contention: req0 and req1 both valid every cycle, issuing reads -> grants alternate 0,1,0,1, and each rsp goes only to its owner.
- REQ-035 SHALL cover same-address turnaround: req1 writes 8'hC3@2, and req0 reads @2 in the next cycle -> rsp0_rdata=C3.
- REQ-036 SHALL cover reset mid-run: assert rst_n=0 in the cycle after a read handshake -> no rspN_valid pulse, ready=0 for 8+ cycles, and all locations read back 8'h00.
- REQ-037 SHALL cover request during INIT: req0_valid=1 immediately after reset -> req0_ready stays 0 until init_done=1, then the access is accepted.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// Shared definitions for the single-port RAM arbiter: controller states and requester count.
package sp_ram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM with a registered one-cycle read; contents are not reset.
module single_port_ram #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= data_in;
        end
        data_out <= mem_q[addr];
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM that is
// cleared to zero after every reset before any access is accepted.
module sp_ram_arbiter
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                pend_q, pend_d;
    logic [NUM_REQ-1:0]  ready_s;
    logic                hs_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic [DATA_W-1:0]   ram_din_s;
    logic                ram_we_s;
    logic [DATA_W-1:0]   ram_dout_s;

    // Controller state, clear counter, last grant and pending-response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= {ADDR_W{1'b0}};
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            pend_q  <= pend_d;
        end
    end

    // Next state, grant selection and RAM port steering.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        pend_d     = 1'b0;
        ready_s    = {NUM_REQ{1'b0}};
        hs_s       = 1'b0;
        ram_addr_s = cnt_q;
        ram_din_s  = {DATA_W{1'b0}};
        ram_we_s   = 1'b0;
        case (state_q)
            ST_INIT: begin
                ram_we_s = rst_n;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                // Under contention the requester not granted last wins.
                ready_s[0] = rst_n & req0_valid & (~req1_valid | last_q);
                ready_s[1] = rst_n & req1_valid & (~req0_valid | ~last_q);
                hs_s       = |ready_s;
                if (ready_s[1]) begin
                    ram_addr_s = req1_addr;
                    ram_din_s  = req1_wdata;
                    ram_we_s   = req1_we;
                end else begin
                    ram_addr_s = req0_addr;
                    ram_din_s  = req0_wdata;
                    ram_we_s   = ready_s[0] & req0_we;
                end
                if (hs_s) begin
                    last_d  = ready_s[1];
                    owner_d = ready_s[1];
                    pend_d  = ~ram_we_s;
                end else begin
                    last_d  = last_q;
                    owner_d = owner_q;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    single_port_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .addr     (ram_addr_s),
        .data_in  (ram_din_s),
        .we       (ram_we_s),
        .clk      (clk),
        .data_out (ram_dout_s)
    );

    assign req0_ready = ready_s[0];
    assign req1_ready = ready_s[1];
    // A pending pulse is suppressed as soon as reset is applied.
    assign rsp0_valid = rst_n & pend_q & ~owner_q;
    assign rsp1_valid = rst_n & pend_q & owner_q;
    assign rsp0_rdata = ram_dout_s;
    assign rsp1_rdata = ram_dout_s;
    assign init_done  = (state_q == ST_RUN);

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: clear after reset, read/write, contention,
// same-address turnaround, reset mid-run and requests issued during the clear.
module tb_sp_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_we;
    logic [2:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       req1_valid, req1_ready, req1_we;
    logic [2:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp0_valid, rsp1_valid, init_done;
    logic [7:0] rsp0_rdata, rsp1_rdata;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    sp_ram_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .init_done  (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic we, input logic [2:0] a, input logic [7:0] d);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [2:0] a, input logic [7:0] d);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    // Waits for init_done with req0 held valid; ready must stay low meanwhile.
    task automatic wait_init(input string tag);
        n = 0;
        while (init_done !== 1'b1 && n < 20) begin
            chk({tag, "_ready0_init"}, 32'(req0_ready), 32'd0);
            cyc();
            n++;
        end
        chk({tag, "_init_cycles"}, 32'(n), 32'd8);
    endtask

    initial begin
        rst_n = 1'b0;
        set0(1'b0, 1'b0, 3'd0, 8'h00);
        set1(1'b0, 1'b0, 3'd0, 8'h00);
        cyc(); cyc(); cyc();
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);

        // Release reset with a read of addr 5 already pending.
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 3'd5, 8'h00);
        wait_init("clr");
        #1;
        chk("clr_ready0", 32'(req0_ready), 32'd1);
        cyc();
        set0(1'b0, 1'b0, 3'd0, 8'h00);
        chk("clr_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("clr_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("clr_rsp0_rdata", 32'(rsp0_rdata), 32'h00);
        cyc();
        chk("clr_rsp0_pulse_end", 32'(rsp0_valid), 32'd0);

        // Writes then back-to-back reads on req0.
        set0(1'b1, 1'b1, 3'd0, 8'hA1);
        #1;
        chk("wr_ready0", 32'(req0_ready), 32'd1);
        cyc();
        set0(1'b1, 1'b1, 3'd1, 8'hB2);
        chk("wr_no_rsp", 32'(rsp0_valid), 32'd0);
        cyc();
        set0(1'b1, 1'b0, 3'd0, 8'h00);
        cyc();
        set0(1'b1, 1'b0, 3'd1, 8'h00);
        chk("rd0_valid", 32'(rsp0_valid), 32'd1);
        chk("rd0_rdata", 32'(rsp0_rdata), 32'hA1);
        cyc();
        set0(1'b0, 1'b0, 3'd0, 8'h00);
        chk("rd1_valid", 32'(rsp0_valid), 32'd1);
        chk("rd1_rdata", 32'(rsp0_rdata), 32'hB2);
        cyc();

        // req1 writes addr 2, req0 reads it the very next cycle.
        set1(1'b1, 1'b1, 3'd2, 8'hC3);
        #1;
        chk("ta_ready1", 32'(req1_ready), 32'd1);
        cyc();
        set1(1'b0, 1'b0, 3'd0, 8'h00);
        set0(1'b1, 1'b0, 3'd2, 8'h00);
        cyc();
        set0(1'b0, 1'b0, 3'd0, 8'h00);
        chk("ta_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("ta_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("ta_rsp0_rdata", 32'(rsp0_rdata), 32'hC3);

        // Lone req1 read so that req0 wins the next contention.
        set1(1'b1, 1'b0, 3'd2, 8'h00);
        cyc();
        set1(1'b0, 1'b0, 3'd0, 8'h00);
        chk("r1_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("r1_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("r1_rsp1_rdata", 32'(rsp1_rdata), 32'hC3);

        // Contention: both read continuously, grants must alternate 0,1,0,1.
        set0(1'b1, 1'b0, 3'd0, 8'h00);
        set1(1'b1, 1'b0, 3'd1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ct_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            chk("ct_ready1", 32'(req1_ready), 32'(i % 2 == 1));
            cyc();
            chk("ct_rsp0_valid", 32'(rsp0_valid), 32'(i % 2 == 0));
            chk("ct_rsp1_valid", 32'(rsp1_valid), 32'(i % 2 == 1));
            chk("ct_rdata", 32'((i % 2 == 0) ? rsp0_rdata : rsp1_rdata), (i % 2 == 0) ? 32'hA1 : 32'hB2);
        end
        set0(1'b0, 1'b0, 3'd0, 8'h00);
        set1(1'b0, 1'b0, 3'd0, 8'h00);
        cyc();

        // Reset in the cycle after a read handshake.
        set0(1'b1, 1'b0, 3'd0, 8'h00);
        cyc();
        rst_n = 1'b0;
        set0(1'b0, 1'b0, 3'd0, 8'h00);
        #1;
        chk("mr_rsp0_dropped", 32'(rsp0_valid), 32'd0);
        chk("mr_rsp1_dropped", 32'(rsp1_valid), 32'd0);
        cyc();
        cyc();
        chk("mr_init_done", 32'(init_done), 32'd0);
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 3'd0, 8'h00);
        wait_init("mr");
        for (int i = 0; i < 8; i++) begin
            set0(1'b1, 1'b0, 3'(i), 8'h00);
            cyc();
            chk("mr_rd_valid", 32'(rsp0_valid), 32'd1);
            chk("mr_rd_zero", 32'(rsp0_rdata), 32'h00);
        end
        set0(1'b0, 1'b0, 3'd0, 8'h00);
        cyc();
        chk("idle_rsp0", 32'(rsp0_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
